uart_tx_mm: RTL and testbench
=============================

UART_TX_MM -- requirements
Module: uart_tx_mm

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bus data width.
REQ-002 Parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, at least 2.
REQ-003 Parameter CLKS_PER_BIT, default 434, reset baud divisor (50 MHz / 115200).
REQ-004 Port clk, input, 1, single clock; all logic on rising edge.
REQ-005 Port rst, input, 1, synchronous, active-high reset.
REQ-006 Port wd, input, DATA_WIDTH, write data from the memory map.
REQ-007 Port address, input, 32, slave-relative byte address; only address[3:2] is decoded.
REQ-008 Port we, input, 1, write strobe, one access per cycle high.
REQ-009 Port re, input, 1, read strobe.
REQ-010 Port rd, output, DATA_WIDTH, read data.
REQ-011 Port tx, output, 1, serial line; idles high.

Function
REQ-012 Register map by address[3:2]:
- 0 = TXDATA, write-only; pushes wd[7:0].
- 1 = STATUS, read; write-1-to-clear.
- 2 = BAUD, read/write.
- 3 = reserved; reads 0, writes ignored.
REQ-013 STATUS bit layout:
- bit0 full; bit1 empty; bit2 busy (FSM not IDLE); bit3 overflow (sticky).
- bits[7:4] FIFO count; remaining bits 0.
REQ-014 rd is combinational from address when re=1, and 0 when re=0.
REQ-015 A TXDATA write with FIFO not full pushes the byte; count increments at the next edge.
REQ-016 A TXDATA write with FIFO full:
- byte dropped, even if a pop occurs the same cycle;
- overflow set at the next edge.
REQ-017 A STATUS write with wd[3]=1 clears overflow; if a same-cycle overflow event also occurs, set wins.
REQ-018 BAUD write loads wd[15:0]; values below 2 are stored as 2.
REQ-019 The FSM latches the divisor at IDLE->START, so BAUD changes take effect from the next frame.
REQ-020 FSM states and transitions:
- IDLE: tx=1. If FIFO not empty, pop the head byte into a shift register and go to START.
- START: tx=0 for divisor cycles, then DATA.
- DATA: 8 bits LSB first, each for divisor cycles, then STOP.
- STOP: tx=1 for divisor cycles, then IDLE.
REQ-021 IDLE lasts at least 1 cycle between frames; back-to-back frames have exactly 10*divisor+1 cycles from start-bit edge to start-bit edge.
REQ-022 Latency: a write at cycle N to an empty FIFO with FSM in IDLE gives tx=0 first visible at cycle N+2.
REQ-023 The baud counter runs 0..divisor-1 and resets on each bit boundary; the bit index wraps 7->0 only on leaving DATA.
REQ-024 A simultaneous push and pop on a non-full FIFO leaves count unchanged; data order is preserved.
REQ-025 FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.

Reset
REQ-026 When rst=1 at an edge, the block SHALL enter this state:
- FSM IDLE, tx=1, FIFO empty, count 0, overflow 0;
- BAUD = CLKS_PER_BIT, baud counter 0, bit index 0.
REQ-027 Reset mid-frame SHALL abort the frame; tx=1 from the next edge and the FIFO contents are discarded.
REQ-028 rd SHALL be 0 while rst=1.

Structure
REQ-029 Package uart_tx_pkg SHALL hold:
- register offsets and STATUS bit positions;
- the FSM state enum (IDLE, START, DATA, STOP);
- the minimum-divisor constant 2.
REQ-030 The FIFO SHALL be one sub-module, fifo_sync_param, parameterised by width and depth, exposing push, pop, full, empty and count.

Verification (bench uses CLKS_PER_BIT=4)
REQ-031 Write TXDATA 0x55 after reset -> tx=0 at N+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0 of 4 cycles each, then stop=1 for 4; STATUS reads busy=1 during the frame and 0x02 afterwards.
REQ-032 Write 9 bytes 0x01..0x09 in consecutive cycles -> STATUS shows full=1, overflow=1, count=8; exactly 0x01..0x08 are transmitted; 0x09 is never sent.
REQ-033 Write STATUS 0x08 after the overflow -> overflow reads 0; other bits are unchanged.
REQ-034 Write BAUD=1, then TXDATA 0xA3 -> BAUD reads 2; bits last 2 cycles each (LSB-first 1,1,0,0,0,1,0,1).
REQ-035 Two bytes queued back-to-back -> the second start bit falls exactly 41 cycles after the first.
REQ-036 Assert rst during DATA bit 3 -> tx=1 next cycle, STATUS reads 0x02, and no further frame is transmitted.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmit FSM states and the divisor floor.
package uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 4;

  localparam int unsigned BAUD_W      = 16;
  localparam logic [15:0] MIN_DIVISOR = 16'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic logic [15:0] clamp_divisor(input logic [15:0] i_val);
    return (i_val < MIN_DIVISOR) ? MIN_DIVISOR : i_val;
  endfunction

endpackage

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Push when full and pop when empty are ignored.
module fifo_sync_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_mm.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/BAUD registers in front of a
// byte FIFO feeding an 8N1 serialiser with a programmable bit divisor.
module uart_tx_mm
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [31:0]           address,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  tx
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       w_reg;
  logic [31:0]      w_wd32;
  logic             w_wr_tx;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_evt;
  logic             w_ovf_clr;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [7:0]       w_fifo_data;
  logic [31:0]      w_status;
  logic [31:0]      w_rd32;
  logic             w_unused;

  logic              r_ovf;
  logic [BAUD_W-1:0] r_baud;

  tx_state_t         r_state, w_state_n;
  logic [BAUD_W-1:0] r_cnt, w_cnt_n;
  logic [BAUD_W-1:0] r_div, w_div_n;
  logic [2:0]        r_bit, w_bit_n;
  logic [7:0]        r_shift, w_shift_n;
  logic              w_bit_end;

  assign w_reg  = address[3:2];
  assign w_wd32 = 32'(wd);

  assign w_wr_tx   = we && (w_reg == REG_TXDATA);
  assign w_push    = w_wr_tx && !w_full;
  assign w_ovf_evt = w_wr_tx && w_full;
  assign w_ovf_clr = we && (w_reg == REG_STATUS) && w_wd32[STAT_OVF];

  assign w_unused = &{address[31:4], address[1:0], w_wd32[31:16]};

  fifo_sync_param #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_wdata (w_wd32[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // An overflow event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_baud <= BAUD_W'(CLKS_PER_BIT);
    end else begin
      if (w_ovf_evt)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (we && (w_reg == REG_BAUD)) r_baud <= clamp_divisor(w_wd32[15:0]);
    end
  end

  always_comb begin
    w_status = '0;
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_BUSY]  = (r_state != IDLE);
    w_status[STAT_OVF]   = r_ovf;
    w_status[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(w_count);
  end

  always_comb begin
    w_rd32 = '0;
    if (re && !rst) begin
      case (w_reg)
        REG_STATUS: w_rd32 = w_status;
        REG_BAUD:   w_rd32 = {16'b0, r_baud};
        default:    w_rd32 = '0;
      endcase
    end
  end

  assign rd = DATA_WIDTH'(w_rd32);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= BAUD_W'(CLKS_PER_BIT);
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_div   <= w_div_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
    end
  end

  assign w_bit_end = (r_cnt == r_div - 1'b1);

  // Divisor is captured on leaving IDLE so BAUD writes never disturb a frame.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_div_n   = r_div;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        w_bit_n = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_fifo_data;
          w_div_n   = r_baud;
          w_state_n = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_state_n = DATA;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_n   = '0;
            w_state_n = STOP;
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_state_n = IDLE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      START:   tx = 1'b0;
      DATA:    tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mm.sv
// Bench for uart_tx_mm: register table, directed frame sequences and random
// traffic checked every cycle against a frame-timing reference model.
module tb_uart_tx_mm;

  localparam int D0    = 4;
  localparam int DEPTH = 8;
  localparam int MAXC  = 8192;
  localparam logic [31:0] A_TX = 32'h0;
  localparam logic [31:0] A_ST = 32'h4;
  localparam logic [31:0] A_BD = 32'h8;
  localparam logic [31:0] A_RS = 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] address = '0;
  logic [31:0] rd;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_mm #(
    .DATA_WIDTH   (32),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (D0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wd      (wd),
    .address (address),
    .we      (we),
    .re      (re),
    .rd      (rd),
    .tx      (tx)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic        tx_log [MAXC];
  logic [31:0] rd_log [MAXC];
  logic [7:0]  dec_q [$];

  // Reference model: queue of accepted bytes plus the timing of the current frame.
  logic [7:0] m_q [$];
  bit         m_ovf = 1'b0;
  int         m_baud = D0;
  int         m_fs = -100000;
  int         m_fd = 1;
  logic [7:0] m_fb = '0;
  int         m_idle_from = 0;
  bit         m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_tx(input int c);
    int k;
    if (c >= m_fs && c < m_fs + 10 * m_fd) begin
      k = (c - m_fs) / m_fd;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_fb[k-1];
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic r, input logic rr, input logic [31:0] a);
    int sz;
    if (r || !rr) return 32'h0;
    sz = m_q.size();
    case (a[3:2])
      2'd1: return 32'((sz == DEPTH) ? 1 : 0) + 32'((sz == 0) ? 2 : 0) +
                   32'((cyc < m_idle_from) ? 4 : 0) + 32'(m_ovf ? 8 : 0) + 32'(sz * 16);
      2'd2: return 32'(m_baud);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int sz;
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_baud = D0;
      m_fs = -100000;
      m_idle_from = cyc + 1;
      m_valid = 1'b1;
      return;
    end
    sz = m_q.size();
    if (cyc >= m_idle_from && sz > 0) begin
      m_fb = m_q.pop_front();
      m_fd = m_baud;
      m_fs = cyc + 1;
      m_idle_from = cyc + 1 + 10 * m_fd;
    end
    if (w && a[3:2] == 2'd0) begin
      if (sz < DEPTH) m_q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end else if (w && a[3:2] == 2'd1 && d[3]) begin
      m_ovf = 1'b0;
    end
    if (w && a[3:2] == 2'd2) m_baud = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
  endtask

  task automatic step(input logic r, input logic w, input logic rr,
                      input logic [31:0] a, input logic [31:0] d, output logic [31:0] o_rd);
    @(negedge clk);
    rst = r; we = w; re = rr; address = a; wd = d;
    #1;
    o_rd = rd;
    if (cyc < MAXC) begin
      tx_log[cyc] = tx;
      rd_log[cyc] = rd;
    end
    if (m_valid) begin
      chk("tx_model", {31'b0, tx}, {31'b0, exp_tx(cyc)});
      chk("rd_model", rd, exp_rd(r, rr, a));
    end
    @(posedge clk);
    model_edge(r, w, a, d);
    cyc++;
  endtask

  task automatic idle(input int n);
    logic [31:0] v;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, A_ST, 32'h0, v);
  endtask

  function automatic int find_start(input int from, input int to);
    for (int c = from; c <= to && c < MAXC; c++)
      if (c > 0 && tx_log[c-1] === 1'b1 && tx_log[c] === 1'b0) return c;
    return -1;
  endfunction

  task automatic decode(input int from, input int to, input int d);
    int s;
    logic [7:0] b;
    dec_q.delete();
    s = find_start(from, to);
    while (s >= 0 && s + 10 * d <= to) begin
      for (int i = 0; i < 8; i++) b[i] = tx_log[s + d * (i + 1) + d / 2];
      dec_q.push_back(b);
      s = find_start(s + 10 * d, to);
    end
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] v;
    logic [9:0]  pat;
    int          n, s1, s2, zeros, p;
    logic        rr, ww, rs;
    logic [31:0] a, d;

    step(1'b1, 1'b0, 1'b0, A_ST, 32'h0, v);
    step(1'b1, 1'b0, 1'b1, A_ST, 32'h0, v);
    chk("rd_in_reset", v, 32'h0);
    chk("reset_tx", {31'b0, tx_log[cyc-1]}, 32'h1);

    tbl[0]  = '{1'b0, 1'b1, A_ST, 32'h0,         32'h2};
    tbl[1]  = '{1'b0, 1'b1, A_BD, 32'h0,         32'h4};
    tbl[2]  = '{1'b1, 1'b1, A_BD, 32'h1,         32'h4};
    tbl[3]  = '{1'b0, 1'b1, A_BD, 32'h0,         32'h2};
    tbl[4]  = '{1'b1, 1'b0, A_BD, 32'h0,         32'h0};
    tbl[5]  = '{1'b0, 1'b1, A_BD, 32'h0,         32'h2};
    tbl[6]  = '{1'b1, 1'b0, A_BD, 32'h0001_1234, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, A_BD, 32'h0,         32'h1234};
    tbl[8]  = '{1'b1, 1'b1, A_RS, 32'hFFFF_FFFF, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, A_RS, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 1'b1, A_TX, 32'h0,         32'h0};
    tbl[11] = '{1'b1, 1'b0, A_BD, 32'h4,         32'h0};
    tbl[12] = '{1'b0, 1'b1, A_BD, 32'h0,         32'h4};
    tbl[13] = '{1'b1, 1'b1, A_ST, 32'hFF,        32'h2};
    tbl[14] = '{1'b0, 1'b0, A_BD, 32'h0,         32'h0};
    for (int i = 0; i < 15; i++) begin
      step(1'b0, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, v);
      chk($sformatf("tbl%0d", i), v, tbl[i].e);
    end

    // Single frame 0x55 at the reset divisor.
    n = cyc;
    step(1'b0, 1'b1, 1'b0, A_TX, 32'h55, v);
    idle(44);
    chk("A_lat_n1", {31'b0, tx_log[n+1]}, 32'h1);
    pat = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("A_bit%0d", i), {31'b0, tx_log[n + 2 + 4 * i + j]}, {31'b0, pat[i]});
    chk("A_busy", {31'b0, rd_log[n+10][2]}, 32'h1);
    chk("A_status_after", rd_log[n+43], 32'h2);

    // Overflow while a frame is in flight, then clear the sticky flag.
    n = cyc;
    step(1'b0, 1'b1, 1'b0, A_TX, 32'h00, v);
    idle(3);
    for (int b = 1; b <= 9; b++) step(1'b0, 1'b1, 1'b0, A_TX, 32'(b), v);
    step(1'b0, 1'b0, 1'b1, A_ST, 32'h0, v);
    chk("B_status_full", v, 32'h8D);
    step(1'b0, 1'b1, 1'b0, A_ST, 32'h08, v);
    step(1'b0, 1'b0, 1'b1, A_ST, 32'h0, v);
    chk("C_ovf_cleared", v, 32'h85);
    idle(400);
    decode(n, cyc - 1, 4);
    chk("B_nframes", 32'(dec_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < dec_q.size(); i++)
      chk($sformatf("B_byte%0d", i), {24'b0, dec_q[i]}, 32'(i));
    chk("B_status_end", rd_log[cyc-1], 32'h2);

    // Divisor clamp and a 2-cycle bit frame.
    step(1'b0, 1'b1, 1'b0, A_BD, 32'h1, v);
    step(1'b0, 1'b0, 1'b1, A_BD, 32'h0, v);
    chk("D_baud_clamp", v, 32'h2);
    n = cyc;
    step(1'b0, 1'b1, 1'b0, A_TX, 32'hA3, v);
    idle(25);
    pat = {1'b1, 8'hA3, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 2; j++)
        chk($sformatf("D_bit%0d", i), {31'b0, tx_log[n + 2 + 2 * i + j]}, {31'b0, pat[i]});
    step(1'b0, 1'b1, 1'b0, A_BD, 32'h4, v);

    // Back-to-back frames.
    n = cyc;
    step(1'b0, 1'b1, 1'b0, A_TX, 32'h3C, v);
    step(1'b0, 1'b1, 1'b0, A_TX, 32'hC3, v);
    idle(95);
    s1 = find_start(n + 1, cyc - 1);
    s2 = (s1 >= 0) ? find_start(s1 + 40, cyc - 1) : -1;
    chk("E_first_start", 32'(s1), 32'(n + 2));
    chk("E_gap", 32'(s2 - s1), 32'd41);

    // Reset during data bit 3 aborts the frame and drops the queued byte.
    n = cyc;
    step(1'b0, 1'b1, 1'b0, A_TX, 32'h00, v);
    step(1'b0, 1'b1, 1'b0, A_TX, 32'h0F, v);
    idle(17);
    step(1'b1, 1'b0, 1'b1, A_ST, 32'h0, v);
    chk("F_rd_in_reset", v, 32'h0);
    chk("F_tx_bit3", {31'b0, tx_log[n+19]}, 32'h0);
    step(1'b0, 1'b0, 1'b1, A_ST, 32'h0, v);
    chk("F_status_after", v, 32'h2);
    chk("F_tx_after", {31'b0, tx_log[n+20]}, 32'h1);
    idle(60);
    zeros = 0;
    for (int c = n + 20; c < cyc; c++) if (tx_log[c] !== 1'b1) zeros++;
    chk("F_no_frame", 32'(zeros), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      p  = int'($urandom_range(0, 999));
      rs = 1'b0; ww = 1'b0;
      a  = $urandom;
      d  = $urandom;
      rr = 1'($urandom_range(0, 1));
      if (p < 2) rs = 1'b1;
      else if (p < 60) begin ww = 1'b1; a[3:2] = 2'd0; end
      else if (p < 70) begin ww = 1'b1; a[3:2] = 2'd1; end
      else if (p < 74) begin ww = 1'b1; a[3:2] = 2'd2; d[15:0] = 16'($urandom_range(0, 6)); end
      else if (p < 78) begin ww = 1'b1; a[3:2] = 2'd3; end
      step(rs, ww, rr, a, d, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
